bram_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that sequences one external 36x512 simple-dual-port block RAM (separate write port A and read port B, one-cycle read latency, bypass read mode) as a valid/ready stream buffer. It owns the write/read pointers, full/empty tracking and the BRAM enables. It also owns a two-entry output buffer that hides the BRAM read latency. It sits between a pixel/packet producer and a consumer in the camera/display datapath. The BRAM instance stays outside this block and is wired to the `bram_*` ports.

---
 rtl/bram_fifo_pkg.sv | 9 +
 rtl/bram_fifo_obuf.sv | 54 +++++
 rtl/bram_fifo_ctrl.sv | 119 +++++++++++
 tb/tb_bram_fifo_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_fifo_pkg.sv
// Shared constants and types for the BRAM-backed stream FIFO controller.
package bram_fifo_pkg;
  localparam int DW         = 36;
  localparam int AW         = 9;
  localparam int DEPTH      = 2 ** AW;
  localparam int OBUF_DEPTH = 2;

  typedef logic [AW:0] ptr_t;
endpackage

// File: rtl/bram_fifo_obuf.sv
// Two-entry output buffer with a registered head; hides the BRAM read latency.
module bram_fifo_obuf #(
  parameter int DW = 36
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [1:0]    cnt,
  output logic [DW-1:0] head,
  output logic          dummy_unused_never
);
  logic [DW-1:0] tail;

  assign dummy_unused_never = 1'b0;

  // Shift register update: head is always the oldest word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt  <= 2'd0;
      head <= {DW{1'b0}};
      tail <= {DW{1'b0}};
    end else if (clr) begin
      cnt  <= 2'd0;
      head <= {DW{1'b0}};
      tail <= {DW{1'b0}};
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) head <= din;
          else             tail <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end
endmodule

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller sequencing an external 36x512 simple-dual-port BRAM as a valid/ready buffer.
// Optional BRAM_FIFO_LEVEL_EN adds a registered `level` occupancy output.
module bram_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int DW = bram_fifo_pkg::DW,
  parameter int AW = bram_fifo_pkg::AW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          bram_cea,
  output logic [AW-1:0] bram_ada,
  output logic [DW-1:0] bram_din,
  output logic          bram_ceb,
  output logic          bram_oce,
  output logic [AW-1:0] bram_adb,
  input  logic [DW-1:0] bram_dout
`ifdef BRAM_FIFO_LEVEL_EN
  ,
  output logic [AW+1:0] level
`endif
);
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [AW:0] wr_ptr, rd_ptr, ram_cnt;
  logic [AW:0] wr_ptr_next, rd_ptr_next, ram_cnt_next;
  logic        wr_fire, pop, issue, inflight, ram_empty, push;
  logic [1:0]  obuf_cnt;
  logic [2:0]  occ;
  logic        obuf_spare;

  assign ram_cnt   = wr_ptr - rd_ptr;
  assign ram_empty = (ram_cnt == {(AW+1){1'b0}});
  assign pop       = rd_valid && rd_ready;
  assign push      = inflight && !flush;
  assign wr_fire   = wr_valid && wr_ready && !flush;
  // Buffer slots already promised: held words plus the read in flight, minus the word leaving now.
  assign occ       = {1'b0, obuf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = !ram_empty && (occ < 3'(OBUF_DEPTH)) && !flush;

  assign bram_cea = wr_fire;
  assign bram_ada = wr_ptr[AW-1:0];
  assign bram_din = wr_data;
  assign bram_ceb = issue;
  assign bram_adb = rd_ptr[AW-1:0];
  assign bram_oce = 1'b1;
  assign rd_valid = (obuf_cnt != 2'd0);

  // Next pointer values; flush wins over any handshake.
  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (flush) begin
      wr_ptr_next = {(AW+1){1'b0}};
      rd_ptr_next = {(AW+1){1'b0}};
    end else begin
      wr_ptr_next = wr_ptr + (AW+1)'(wr_fire);
      rd_ptr_next = rd_ptr + (AW+1)'(issue);
    end
    ram_cnt_next = wr_ptr_next - rd_ptr_next;
  end

  // Pointer, in-flight and write-ready state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= {(AW+1){1'b0}};
      rd_ptr   <= {(AW+1){1'b0}};
      inflight <= 1'b0;
      wr_ready <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_next;
      rd_ptr   <= rd_ptr_next;
      inflight <= issue;
      wr_ready <= (ram_cnt_next != FULL_CNT) && !flush;
    end
  end

  bram_fifo_obuf #(.DW(DW)) u_obuf (
    .clk                (clk),
    .resetn             (resetn),
    .clr                (flush),
    .push               (push),
    .pop                (pop),
    .din                (bram_dout),
    .cnt                (obuf_cnt),
    .head               (rd_data),
    .dummy_unused_never (obuf_spare)
  );

`ifdef BRAM_FIFO_LEVEL_EN
  logic [1:0] obuf_cnt_next;

  // Buffer count after this edge, mirroring the sub-module update.
  always_comb begin
    obuf_cnt_next = obuf_cnt;
    if (flush) begin
      obuf_cnt_next = 2'd0;
    end else begin
      obuf_cnt_next = obuf_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Total words held after this edge: RAM, output buffer and the read in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level <= {(AW+2){1'b0}};
    end else begin
      level <= (AW+2)'(ram_cnt_next) + (AW+2)'(obuf_cnt_next) + (AW+2)'(issue);
    end
  end
`endif
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Scoreboard bench for bram_fifo_ctrl with a behavioural one-cycle-latency BRAM model.
module tb_bram_fifo_ctrl;
  import bram_fifo_pkg::*;

  logic          clk = 1'b0;
  logic          resetn, flush, wr_valid, wr_ready, rd_valid, rd_ready;
  logic [DW-1:0] wr_data, rd_data, bram_din, bram_dout;
  logic          bram_cea, bram_ceb, bram_oce;
  logic [AW-1:0] bram_ada, bram_adb;
`ifdef BRAM_FIFO_LEVEL_EN
  logic [AW+1:0] level;
`endif

  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] exp_q [$];
  int            total = 0;
  int            bad   = 0;
  int            n_pop = 0;

  always #5 clk = ~clk;

  bram_fifo_ctrl dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .bram_cea(bram_cea), .bram_ada(bram_ada), .bram_din(bram_din),
    .bram_ceb(bram_ceb), .bram_oce(bram_oce), .bram_adb(bram_adb),
    .bram_dout(bram_dout)
`ifdef BRAM_FIFO_LEVEL_EN
    , .level(level)
`endif
  );

  always @(posedge clk) begin
    if (bram_cea) mem[bram_ada] <= bram_din;
    if (bram_ceb) bram_dout <= mem[bram_adb];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: compares each consumed word against the oldest accepted one.
  always @(negedge clk) begin : monitor
    logic [DW-1:0] e;
    if (resetn && rd_valid && rd_ready) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %0h expected none", rd_data);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", {28'd0, rd_data}, {28'd0, e});
      end
    end
    if (!resetn || flush) exp_q.delete();
    if (resetn && wr_valid && wr_ready && !flush) exp_q.push_back(wr_data);
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   acc, p0, gaps;
    logic a;
    resetn = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = 36'd0;
    repeat (3) step();
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 36'd0);
    chk("rst_cea", bram_cea, 1'b0);
    chk("rst_ceb", bram_ceb, 1'b0);
    resetn = 1'b1;
    step();
    chk("rel_wr_ready", wr_ready, 1'b1);
    chk("rel_rd_valid", rd_valid, 1'b0);
    step();
    chk("empty_ceb", bram_ceb, 1'b0);
    chk("oce", bram_oce, 1'b1);

    // single write and 3-cycle latency
    wr_valid = 1'b1; wr_data = 36'h123456789;
    #1;
    chk("w1_cea", bram_cea, 1'b1);
    chk("w1_ada", bram_ada, 9'd0);
    chk("w1_din", bram_din, 36'h123456789);
    step();
    wr_valid = 1'b0;
    chk("w1_ceb", bram_ceb, 1'b1);
    chk("w1_adb", bram_adb, 9'd0);
    chk("w1_rv_e0", rd_valid, 1'b0);
    step();
    chk("w1_rv_e1", rd_valid, 1'b0);
    step();
    chk("w1_rv_e2", rd_valid, 1'b1);
    chk("w1_data", rd_data, 36'h123456789);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("w1_drained", rd_valid, 1'b0);

    // fill to capacity with the consumer stalled
    p0 = n_pop; acc = 0; wr_data = 36'd0; wr_valid = 1'b1;
    for (int c = 0; c < 1000 && acc < 514; c++) begin
      a = wr_ready;
      step();
      if (a) begin
        acc++;
        wr_data = 36'(acc);
      end
    end
    wr_valid = 1'b0;
    chk("fill_count", acc, 514);
    chk("fill_wr_ready", wr_ready, 1'b0);
`ifdef BRAM_FIFO_LEVEL_EN
    chk("fill_level", level, 11'd514);
`endif
    step(); step();
    chk("full_wr_ready", wr_ready, 1'b0);
    chk("full_head", rd_data, 36'd0);
    chk("full_ceb", bram_ceb, 1'b0);
    rd_ready = 1'b1;
    #1;
    chk("drain_issue_ceb", bram_ceb, 1'b1);
    chk("drain_wr_ready_same", wr_ready, 1'b0);
    step();
    chk("drain_wr_ready_after", wr_ready, 1'b1);
    for (int c = 0; c < 700; c++) begin
      if (!rd_valid) break;
      step();
    end
    rd_ready = 1'b0;
    chk("fill_pops", n_pop - p0, 514);
    chk("fill_q_empty", exp_q.size(), 0);

    // sustained streaming, wraps the pointers several times
    p0 = n_pop; gaps = 0; wr_valid = 1'b1; rd_ready = 1'b1; wr_data = 36'd1000;
    for (int s = 1; s <= 2002; s++) begin
      if (s <= 2000 && !wr_ready) gaps++;
      step();
      if (s == 2000) wr_valid = 1'b0;
      else           wr_data = wr_data + 36'd1;
      if (s >= 3 && !rd_valid) gaps++;
    end
    chk("stream_gaps", gaps, 0);
    step();
    rd_ready = 1'b0;
    chk("stream_end_rv", rd_valid, 1'b0);
    chk("stream_pops", n_pop - p0, 2000);

    // random handshakes
    p0 = n_pop; acc = 0; wr_data = 36'h10000;
    for (int c = 0; c < 40000 && acc < 5000; c++) begin
      wr_valid = 1'($urandom_range(0, 1));
      rd_ready = 1'($urandom_range(0, 1));
      #1;
      a = wr_valid && wr_ready;
      step();
      if (a) begin
        acc++;
        wr_data = wr_data + 36'd1;
      end
    end
    wr_valid = 1'b0; rd_ready = 1'b1;
    for (int c = 0; c < 700; c++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    step(); step();
    rd_ready = 1'b0;
    chk("rand_count", acc, 5000);
    chk("rand_pops", n_pop - p0, 5000);
    chk("rand_rv_idle", rd_valid, 1'b0);

    // flush with data stored and a read in flight
    acc = 0; wr_data = 36'h20000; wr_valid = 1'b1;
    for (int c = 0; c < 300 && acc < 100; c++) begin
      a = wr_ready;
      step();
      if (a) begin
        acc++;
        wr_data = wr_data + 36'd1;
      end
    end
    wr_valid = 1'b0;
    step();
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0; flush = 1'b1;
    #1;
    chk("flush_ceb", bram_ceb, 1'b0);
    step();
    flush = 1'b0;
    chk("flush_rv", rd_valid, 1'b0);
    chk("flush_wr_ready", wr_ready, 1'b0);
`ifdef BRAM_FIFO_LEVEL_EN
    chk("flush_level", level, 11'd0);
`endif
    step();
    chk("flush_wr_ready_back", wr_ready, 1'b1);
    chk("flush_rv_idle", rd_valid, 1'b0);
    wr_valid = 1'b1; wr_data = 36'hABC;
    step();
    wr_valid = 1'b0;
    step();
    chk("flush_lat_e1", rd_valid, 1'b0);
    step();
    chk("flush_lat_e2", rd_valid, 1'b1);
    chk("flush_first", rd_data, 36'hABC);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("flush_q_empty", exp_q.size(), 0);

    // asynchronous reset mid-stream
    wr_valid = 1'b1; rd_ready = 1'b1; wr_data = 36'h30000;
    for (int c = 0; c < 40; c++) begin
      step();
      wr_data = wr_data + 36'd1;
    end
    resetn = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    #1;
    chk("arst_rv", rd_valid, 1'b0);
    chk("arst_wr_ready", wr_ready, 1'b0);
    chk("arst_cea", bram_cea, 1'b0);
    chk("arst_ceb", bram_ceb, 1'b0);
    chk("arst_rd_data", rd_data, 36'd0);
    step(); step();
    resetn = 1'b1;
    step();
    chk("arst_rel_wr_ready", wr_ready, 1'b1);
    chk("arst_rel_rv", rd_valid, 1'b0);
    wr_valid = 1'b1; wr_data = 36'hDEF;
    step();
    wr_valid = 1'b0;
    step(); step();
    chk("arst_first_rv", rd_valid, 1'b1);
    chk("arst_first", rd_data, 36'hDEF);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    step();
    chk("final_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
